// File: rtl/countdown_timer.sv
// countdown_timer: loadable 8-bit prescaled down-counter with pause/resume, done flag and two seven-segment digits
module countdown_timer #(
    parameter int PRESCALE = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [7:0] load_value_i,
    input  logic       load_i,
    input  logic       start_i,
    input  logic       pause_i,
    output logic [7:0] count_o,
    output logic       running_o,
    output logic       done_o,
    output logic [6:0] hex0_o,
    output logic [6:0] hex1_o
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic [7:0] pre_q, pre_d;
    logic [6:0] hex0_q, hex1_q;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    endfunction

    // next state: load beats start, start only acts in IDLE, then run/pause/tick handling
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        if (load_i) begin
            count_d = load_value_i;
            pre_d   = '0;
            state_d = IDLE;
        end else if (start_i && state_q == IDLE) begin
            pre_d   = '0;
            state_d = (count_q != 8'd0) ? RUN : DONE;
        end else begin
            case (state_q)
                RUN: begin
                    if (pause_i) begin
                        state_d = PAUSED;
                    end else if (pre_q == LAST) begin
                        pre_d = '0;
                        if (count_q != 8'd0) count_d = count_q - 8'd1;
                        if (count_q <= 8'd1) state_d = DONE;
                    end else begin
                        pre_d = pre_q + 8'd1;
                    end
                end
                PAUSED:  state_d = pause_i ? PAUSED : RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // state, count and prescale phase registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
        end
    end

    // segment digits registered from the current count, one cycle behind it
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hex0_q <= seg(4'h0);
            hex1_q <= seg(4'h0);
        end else begin
            hex0_q <= seg(count_q[3:0]);
            hex1_q <= seg(count_q[7:4]);
        end
    end

    assign count_o   = count_q;
    assign running_o = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign hex0_o    = hex0_q;
    assign hex1_o    = hex1_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of countdown_timer with PRESCALE=4
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] load_value = '0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] count;
    logic       running, done;
    logic [6:0] hex0, hex1;
    int tests = 0;
    int fails = 0;

    countdown_timer #(.PRESCALE(4)) dut (
        .clock_i(clk), .reset_i(reset), .load_value_i(load_value), .load_i(load),
        .start_i(start), .pause_i(pause), .count_o(count), .running_o(running),
        .done_o(done), .hex0_o(hex0), .hex1_o(hex1)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load_value = v;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset and idle
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(5);
        chk("rst_count", count, 8'h00);
        chk("rst_running", {7'd0, running}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_hex0", {1'b0, hex0}, 8'b01000000);
        chk("rst_hex1", {1'b0, hex1}, 8'b01000000);
        // 2: load 3 and count down to done
        do_load(8'h03);
        chk("t2_loaded", count, 8'h03);
        do_start();
        chk("t2_running", {7'd0, running}, 8'd1);
        step(3);
        chk("t2_c3_hold", count, 8'h03);
        step(1);
        chk("t2_c4", count, 8'h02);
        chk("t2_hex0_lag", {1'b0, hex0}, 8'b00110000);
        step(1);
        chk("t2_hex0_2", {1'b0, hex0}, 8'b00100100);
        step(3);
        chk("t2_c8", count, 8'h01);
        step(4);
        chk("t2_c12", count, 8'h00);
        chk("t2_done", {7'd0, done}, 8'd1);
        chk("t2_run_off", {7'd0, running}, 8'd0);
        chk("t2_hex0_1", {1'b0, hex0}, 8'b01111001);
        step(1);
        chk("t2_hex0_0", {1'b0, hex0}, 8'b01000000);
        // 3: pause mid-interval preserves prescale phase
        do_load(8'h2F);
        do_start();
        step(2);
        pause = 1'b1;
        step(1);
        chk("t3_paused_run", {7'd0, running}, 8'd0);
        step(9);
        chk("t3_frozen", count, 8'h2F);
        chk("t3_paused_run2", {7'd0, running}, 8'd0);
        pause = 1'b0;
        step(1);
        chk("t3_resumed", {7'd0, running}, 8'd1);
        step(1);
        chk("t3_pre_dec", count, 8'h2F);
        step(1);
        chk("t3_dec", count, 8'h2E);
        // 4: zero start goes straight to done; start ignored in DONE
        do_load(8'h00);
        do_start();
        chk("t4_done", {7'd0, done}, 8'd1);
        chk("t4_count", count, 8'h00);
        do_start();
        chk("t4_done_hold", {7'd0, done}, 8'd1);
        chk("t4_run_off", {7'd0, running}, 8'd0);
        do_load(8'h05);
        chk("t4_done_clr", {7'd0, done}, 8'd0);
        chk("t4_count5", count, 8'h05);
        chk("t4_idle", {7'd0, running}, 8'd0);
        // 5: load wins over start during RUN
        do_load(8'h11);
        do_start();
        step(4);
        chk("t5_c10", count, 8'h10);
        load_value = 8'hA7;
        load = 1'b1;
        start = 1'b1;
        step(1);
        load = 1'b0;
        start = 1'b0;
        chk("t5_count", count, 8'hA7);
        chk("t5_idle", {7'd0, running}, 8'd0);
        chk("t5_hex1_lag", {1'b0, hex1}, 8'b01111001);
        step(1);
        chk("t5_hex1", {1'b0, hex1}, 8'b00001000);
        chk("t5_hex0", {1'b0, hex0}, 8'b01111000);
        chk("t5_still_idle", count, 8'hA7);
        // 6: reset mid-RUN clears prescale phase
        do_load(8'h41);
        do_start();
        step(4);
        chk("t6_c40", count, 8'h40);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_count", count, 8'h00);
        chk("t6_running", {7'd0, running}, 8'd0);
        chk("t6_done", {7'd0, done}, 8'd0);
        chk("t6_hex0", {1'b0, hex0}, 8'b01000000);
        do_load(8'h02);
        do_start();
        step(3);
        chk("t6_c3_hold", count, 8'h02);
        step(1);
        chk("t6_c4", count, 8'h01);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable 8-bit down-counter that is the countdown counterpart to the lab's up-counting T-flip-flop counter. It loads a start value, decrements once every PRESCALE clock cycles while running, and supports pause/resume. It stops at zero and flags done. The count is shown on two active-low seven-segment digits (hex1 = high nibble, hex0 = low nibble), for use directly on the board's HEX outputs.

Parameters:
PRESCALE, 4, clock cycles per decrement while running; legal range 1..255 (1 = decrement every cycle).

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
load_value  input  8  value captured into count on load
load  input  1  load request; sampled every cycle
start  input  1  start request; sampled every cycle
pause  input  1  level; holds countdown while high
count  output  8  current count value (registered)
running  output  1  high in RUN state
done  output  1  high in DONE state
hex0  output  7  low-nibble segments, active-low, bit0=a .. bit6=g
hex1  output  7  high-nibble segments, active-low, bit0=a .. bit6=g

Behaviour:
- States: IDLE, RUN, PAUSED, DONE. running = (state==RUN); done = (state==DONE). Both are registered, with no combinational path from inputs.
- Reset (synchronous, highest priority):
  - state=IDLE, count=0x00, prescale counter=0, running=0, done=0.
  - hex0 = hex1 = 7'b1000000 (digit "0").
- Priority on each edge: reset > load > start > pause/tick logic.
- load (any state): count <= load_value, prescale counter <= 0, state <= IDLE, done cleared next cycle.
- start:
  - Acts only in IDLE. With count != 0, go to RUN with prescale counter 0. With count == 0, go directly to DONE.
  - Ignored in RUN, PAUSED and DONE.
- RUN:
  - If pause=1, go to PAUSED. The prescale counter holds and no decrement happens, even if this cycle would have ticked.
  - Otherwise the prescale counter increments. When it equals PRESCALE-1, it wraps to 0 and count decrements by 1.
  - On a decrement where count==1, count becomes 0 and state becomes DONE in the same edge.
  - First decrement occurs PRESCALE cycles after the start edge.
- PAUSED: count and prescale counter hold. pause=0 returns to RUN on the next edge, resuming the preserved prescale phase.
- DONE: count holds at 0x00 and done stays high. Left only by load or reset.
- No wrap-around: count never decrements below 0x00. Unsigned 8-bit arithmetic throughout.
- Segment encoding:
  - Registered from count, so hex0/hex1 lag count by exactly one cycle.
  - Standard active-low hex glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset mid-RUN or mid-PAUSED: next edge returns to the reset values above, with no residual prescale phase.

Test Plan:
1. Reset then idle 5 cycles -> count=0x00, running=0, done=0, hex1=hex0=1000000.
2. PRESCALE=4: load 0x03, start -> running=1. Count reads 0x02, 0x01, 0x00 on cycles 4, 8, 12 after start. done=1 and running=0 in the same cycle count reaches 0. hex0 shows 1000000 one cycle later.
3. Load 0x2F, start, pause high for 10 cycles mid-interval, then release -> count frozen and running=0 while paused. Next decrement occurs after the remaining prescale cycles only; total elapsed to 0x2E = 4 + 10 (+1 resume edge).
4. Load 0x00, start -> done=1 the next cycle, count stays 0x00. Assert start again in DONE -> no change. Load 0x05 -> done=0, state IDLE, count=0x05.
5. During RUN at count 0x10, assert load (0xA7) and start in the same cycle -> count=0xA7, state IDLE, running=0. Hex outputs become hex1=0001000 and hex0=1111000 one cycle later.
6. Assert reset while RUN at count 0x40 -> next edge: count=0x00, running=0, done=0. A subsequent load 0x02 plus start gives the first decrement exactly PRESCALE cycles after start.
